// File: rtl/spi_slave_if.sv
// Signal bundle for the SPI mode-0 slave: serial pins plus the byte-level tx/rx handshake.
// The slave modport is the DUT side; the master modport is the bus/consumer side.
interface spi_slave_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned FCNT_W = 3
);
   logic              SCLK;
   logic              CS;
   logic              MOSI;
   logic              MISO;
   logic [DATA_W-1:0] tx_data_i;
   logic              tx_load_o;
   logic [DATA_W-1:0] rx_data_o;
   logic              rx_valid_o;
   logic              rx_ack_i;
   logic [FCNT_W-1:0] frame_cnt_o;
   logic              ovr_o;

   modport slave (
      input  SCLK, CS, MOSI, tx_data_i, rx_ack_i,
      output MISO, tx_load_o, rx_data_o, rx_valid_o, frame_cnt_o, ovr_o
   );

   modport master (
      output SCLK, CS, MOSI, tx_data_i, rx_ack_i,
      input  MISO, tx_load_o, rx_data_o, rx_valid_o, frame_cnt_o, ovr_o
   );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled in the clk domain, back-to-back frames under one CS.
// Define SPI_SLAVE_OVR_EN to drop bytes that arrive while rx_valid_o is pending and flag ovr_o.
module spi_slave #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FCNT_W      = 3
) (
   input logic        clk,
   input logic        rst,
   spi_slave_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_fall;
   logic [DATA_W-1:0]      shift_tx_q, shift_tx_d;
   logic [DATA_W-1:0]      shift_rx_q, shift_rx_d;
   logic [DATA_W-1:0]      rx_data_q, rx_data_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic                   miso_q, miso_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   tx_load;
   logic [FCNT_W-1:0]      frame_cnt_q, frame_cnt_d;
`ifdef SPI_SLAVE_OVR_EN
   logic                   ovr_q, ovr_d;
`endif

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // CS chain resets high so leaving reset never looks like a select
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         state_q     <= StIdle;
         shift_tx_q  <= '0;
         shift_rx_q  <= '0;
         rx_data_q   <= '0;
         bit_cnt_q   <= '0;
         miso_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_cnt_q <= '0;
`ifdef SPI_SLAVE_OVR_EN
         ovr_q       <= 1'b0;
`endif
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         state_q     <= state_d;
         shift_tx_q  <= shift_tx_d;
         shift_rx_q  <= shift_rx_d;
         rx_data_q   <= rx_data_d;
         bit_cnt_q   <= bit_cnt_d;
         miso_q      <= miso_d;
         rx_valid_q  <= rx_valid_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef SPI_SLAVE_OVR_EN
         ovr_q       <= ovr_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_tx_d  = shift_tx_q;
      shift_rx_d  = shift_rx_q;
      rx_data_d   = rx_data_q;
      bit_cnt_d   = bit_cnt_q;
      miso_d      = miso_q;
      rx_valid_d  = rx_valid_q;
      frame_cnt_d = frame_cnt_q;
      tx_load     = 1'b0;
`ifdef SPI_SLAVE_OVR_EN
      ovr_d       = ovr_q;
`endif
      if (rx_valid_q && bus.rx_ack_i) rx_valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               frame_cnt_d = '0;
               state_d     = StLoad;
            end
         end
         StLoad: begin
            if (cs_s) begin
               miso_d  = 1'b0;
               state_d = StIdle;
            end else begin
               shift_tx_d = bus.tx_data_i;
               miso_d     = bus.tx_data_i[DATA_W-1];
               tx_load    = 1'b1;
               bit_cnt_d  = '0;
               state_d    = StShift;
            end
         end
         StShift: begin
            if (cs_s) begin
               miso_d  = 1'b0;
               state_d = StIdle;
            end else if (sclk_rise) begin
               shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_d == CNT_W'(DATA_W)) state_d = StDone;
            end else if (sclk_fall && bit_cnt_q != '0 && bit_cnt_q < CNT_W'(DATA_W)) begin
               // bit_cnt==0 filters the trailing fall of the previous frame's last bit
               miso_d     = shift_tx_q[DATA_W-2];
               shift_tx_d = {shift_tx_q[DATA_W-2:0], 1'b0};
            end
         end
         StDone: begin
            rx_valid_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
`ifdef SPI_SLAVE_OVR_EN
            if (rx_valid_q && !bus.rx_ack_i) ovr_d = 1'b1;
            else rx_data_d = shift_rx_q;
`else
            rx_data_d = shift_rx_q;
`endif
            if (cs_s) begin
               miso_d  = 1'b0;
               state_d = StIdle;
            end else begin
               state_d = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.MISO        = miso_q;
   assign bus.tx_load_o   = tx_load;
   assign bus.rx_data_o   = rx_data_q;
   assign bus.rx_valid_o  = rx_valid_q;
   assign bus.frame_cnt_o = frame_cnt_q;
`ifdef SPI_SLAVE_OVR_EN
   assign bus.ovr_o       = ovr_q;
`else
   assign bus.ovr_o       = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: SPI master model at clk/8 with rx and MISO scoreboards.
module tb_spi_slave;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_slave_if #(.DATA_W(8), .FCNT_W(3)) bus ();

   spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .FCNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_cmp    = 0;
   int         n_bad    = 0;
   int         n_load   = 0;
   int         pres_gen = 0;
   int         pres_seen = 0;
   bit         upd      = 1'b0;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];
   logic [7:0] tx_pres[$];

   // Presents queued tx bytes and records every byte the DUT captures
   always @(negedge clk) begin
      if (upd || pres_seen != pres_gen) begin
         pres_seen = pres_gen;
         upd       = 1'b0;
         if (tx_pres.size() > 0) bus.tx_data_i = tx_pres.pop_front();
      end
      if (bus.tx_load_o === 1'b1) begin
         n_load++;
         exp_miso.push_back(bus.tx_data_i);
         upd = 1'b1;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [7:0] b);
      tx_pres.push_back(b);
      pres_gen++;
      tick(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic start_frame();
      exp_miso.delete();
      bus.CS = 1'b0;
      tick(6);
   endtask

   task automatic end_frame();
      tick(2);
      bus.CS = 1'b1;
      tick(6);
      exp_miso.delete();
   endtask

   // Drives nbits MSB-first; SCLK phases are 4 clk each
   task automatic send(input string tag, input logic [7:0] d, input int nbits,
                       input bit ack_done, output int loads_at_last);
      logic [7:0] got = '0;
      loads_at_last = n_load;
      for (int i = 0; i < nbits; i++) begin
         bus.MOSI = d[7-i];
         tick(4);
         bus.SCLK = 1'b1;
         got = {got[6:0], bus.MISO};
         if (i == nbits - 1) begin
            tick(1);
            loads_at_last = n_load;
            if (ack_done) begin
               // third negedge after the last rise falls inside the DONE cycle
               tick(2);
               bus.rx_ack_i = 1'b1;
               tick(1);
               bus.rx_ack_i = 1'b0;
            end else begin
               tick(3);
            end
         end else begin
            tick(4);
         end
         bus.SCLK = 1'b0;
      end
      if (nbits == 8) begin
         check({tag, "_miso_pending"}, 32'(exp_miso.size() > 0), 32'd1);
         if (exp_miso.size() > 0) check({tag, "_miso"}, 32'(got), 32'(exp_miso.pop_front()));
      end
   endtask

   task automatic check_rx(input string tag, input int exp_cnt);
      tick(2);
      check({tag, "_valid"}, 32'(bus.rx_valid_o), 32'd1);
      check({tag, "_rx_pending"}, 32'(exp_rx.size() > 0), 32'd1);
      if (exp_rx.size() > 0) check({tag, "_rx_data"}, 32'(bus.rx_data_o), 32'(exp_rx.pop_front()));
      check({tag, "_fcnt"}, 32'(bus.frame_cnt_o), 32'(exp_cnt));
   endtask

   task automatic ack(input string tag);
      bus.rx_ack_i = 1'b1;
      tick(1);
      bus.rx_ack_i = 1'b0;
      check({tag, "_ack_clear"}, 32'(bus.rx_valid_o), 32'd0);
   endtask

   initial begin
      int la;
      int base;
      bus.SCLK     = 1'b0;
      bus.CS       = 1'b1;
      bus.MOSI     = 1'b0;
      bus.rx_ack_i = 1'b0;
      rst          = 1'b1;
      present(8'h00);

      // 1: reset
      base = n_load;
      do_reset();
      check("rst_miso", 32'(bus.MISO), 32'd0);
      check("rst_load", 32'(bus.tx_load_o), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data_o), 32'd0);
      check("rst_valid", 32'(bus.rx_valid_o), 32'd0);
      check("rst_fcnt", 32'(bus.frame_cnt_o), 32'd0);
      check("rst_ovr", 32'(bus.ovr_o), 32'd0);
      check("rst_no_pulse", 32'(n_load - base), 32'd0);

      // 2: single frame, MISO returns 0xA5
      present(8'hA5);
      base = n_load;
      start_frame();
      exp_rx.push_back(8'h3C);
      send("t2", 8'h3C, 8, 1'b0, la);
      check("t2_loads", 32'(la - base), 32'd1);
      check_rx("t2", 1);
      end_frame();
      check("t2_miso_idle", 32'(bus.MISO), 32'd0);
      ack("t2");

      // 3: three back-to-back frames, fresh tx byte after each load
      present(8'hC3);
      tx_pres.push_back(8'h96);
      tx_pres.push_back(8'h7E);
      start_frame();
      exp_rx.push_back(8'hAA);
      send("t3a", 8'hAA, 8, 1'b0, la);
      check_rx("t3a", 1);
      ack("t3a");
      exp_rx.push_back(8'h55);
      send("t3b", 8'h55, 8, 1'b0, la);
      check_rx("t3b", 2);
      ack("t3b");
      exp_rx.push_back(8'h5D);
      send("t3c", 8'h5D, 8, 1'b0, la);
      check_rx("t3c", 3);
      ack("t3c");
      end_frame();

      // 4: abort after 4 bits, then a clean frame
      present(8'hE7);
      start_frame();
      send("t4p", 8'hF0, 4, 1'b0, la);
      bus.CS = 1'b1;
      tick(6);
      exp_miso.delete();
      check("t4_abort_valid", 32'(bus.rx_valid_o), 32'd0);
      check("t4_abort_miso", 32'(bus.MISO), 32'd0);
      check("t4_abort_data", 32'(bus.rx_data_o), 32'h5D);
      start_frame();
      exp_rx.push_back(8'h81);
      send("t4", 8'h81, 8, 1'b0, la);
      check_rx("t4", 1);
      end_frame();
      ack("t4");

      // 5: overrun, two frames without ack
      do_reset();
      start_frame();
      exp_rx.push_back(8'h11);
      send("t5a", 8'h11, 8, 1'b0, la);
      check_rx("t5a", 1);
`ifdef SPI_SLAVE_OVR_EN
      exp_rx.push_back(8'h11);
`else
      exp_rx.push_back(8'h22);
`endif
      send("t5b", 8'h22, 8, 1'b0, la);
      check_rx("t5b", 2);
      end_frame();
`ifdef SPI_SLAVE_OVR_EN
      check("t5_ovr", 32'(bus.ovr_o), 32'd1);
`else
      check("t5_ovr", 32'(bus.ovr_o), 32'd0);
`endif

      // 6: ack lands on frame 2's DONE cycle
      do_reset();
      start_frame();
      exp_rx.push_back(8'h33);
      send("t6a", 8'h33, 8, 1'b0, la);
      check_rx("t6a", 1);
      exp_rx.push_back(8'hC4);
      send("t6b", 8'hC4, 8, 1'b1, la);
      check_rx("t6b", 2);
      check("t6_ovr", 32'(bus.ovr_o), 32'd0);
      end_frame();
      check("t6_valid_after", 32'(bus.rx_valid_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
